vr_rr_arbiter: RTL

N-to-1 arbiter that shares one valid/ready byte channel between several upstream requesters. Grants rotate round-robin, with a bounded burst lock so a requester can stream up to MAX_BURST consecutive beats before being pre-empted. The output is a single registered stage, so the shared downstream link sees a clean valid/data/id register. The block sits in front of a shared pipeline stage or sink and carries full throughput: one beat per cycle.

---
 rtl/vr_rr_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/vr_rr_arbiter.sv
// Round-robin N-to-1 valid/ready arbiter with bounded burst lock and a single
// registered output stage (valid/data/id) towards the shared downstream link.
module vr_rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]       out_data_o,
    output logic                    out_valid_o,
    output logic [ID_W-1:0]         out_id_o,
    input  logic                    out_ready_i,
    output logic                    lock_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    logic [0:0]        state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   owner;
    logic [CNT_W-1:0]  beat_cnt;

    logic              load_en;
    logic              locked;
    logic              owner_valid;
    logic              win_vld;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   ptr_nxt;
    logic [CNT_W-1:0]  beat_nxt;
    logic [DATA_W-1:0] win_data;
    logic              xfer;

    assign load_en     = ~out_valid_o | out_ready_i;
    assign locked      = (state == ST_LOCKED);
    assign lock_o      = locked;
    assign owner_valid = req_valid_i[owner];

    // A locked owner keeps the grant only while valid; otherwise the rotating
    // search from ptr (already owner+1) picks the next winner in the same cycle.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] cand;
        sum     = '0;
        cand    = '0;
        win     = '0;
        win_vld = 1'b0;
        if (locked && owner_valid) begin
            win     = owner;
            win_vld = 1'b1;
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                sum = {1'b0, ptr} + (ID_W+1)'(k);
                if (sum >= (ID_W+1)'(N_REQ))
                    sum = sum - (ID_W+1)'(N_REQ);
                cand = sum[ID_W-1:0];
                if (!win_vld && req_valid_i[cand]) begin
                    win     = cand;
                    win_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (win == ID_W'(j))
                win_data = req_data_i[j*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (rst_n && win_vld && load_en)
            req_ready_o[win] = 1'b1;
    end

    assign xfer     = win_vld & load_en;
    assign ptr_nxt  = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    assign beat_nxt = beat_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_id_o    <= '0;
            state       <= ST_UNLOCKED;
            ptr         <= '0;
            owner       <= '0;
            beat_cnt    <= '0;
        end else if (load_en) begin
            if (xfer) begin
                out_data_o  <= win_data;
                out_id_o    <= win;
                out_valid_o <= 1'b1;
            end else begin
                out_valid_o <= 1'b0;
            end

            if (locked && owner_valid) begin
                if (beat_nxt == CNT_W'(MAX_BURST)) begin
                    state    <= ST_UNLOCKED;
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_nxt;
                end
            end else if (xfer) begin
                ptr      <= ptr_nxt;
                owner    <= win;
                beat_cnt <= CNT_W'(1);
                state    <= (MAX_BURST > 1) ? ST_LOCKED : ST_UNLOCKED;
            end else begin
                state    <= ST_UNLOCKED;
                beat_cnt <= '0;
            end
        end
    end

endmodule
